// File: rtl/serial_parity_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker_if
// Description : Bundle of framing inputs and checked-word outputs for
//               serial_parity_checker. The master drives the serial stream,
//               the slave (the checker) returns the framed result.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8
);
    localparam int c_cnt_w = $clog2(DATA_BITS + 1);

    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic [c_cnt_w-1:0]   bit_count;
    logic                 frame_done;
    logic                 parity_ok;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data_out;

    modport master (
        output start, bit_in, bit_valid,
        input  busy, bit_count, frame_done, parity_ok, parity_err, data_out
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output busy, bit_count, frame_done, parity_ok, parity_err, data_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Frames a single-bit stream into DATA_BITS data bits (LSB
//               first) plus one parity bit, folds the data through a running
//               XOR and reports the word with a pass/fail parity flag.
// Revision    : 1.0  initial release
// ============================================================================
module serial_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_parity_checker_if.slave  bus
);

    localparam int                 c_cnt_w = $clog2(DATA_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_acc;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ok;
    logic                 r_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 w_err;

    // Parity bit mismatches the folded data parity (inverted for odd parity)
    assign w_err = bus.bit_in ^ r_acc ^ ODD;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; stray bit_valid outside DATA/PARITY is ignored here
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_DATA;
            S_DATA:   if (bus.bit_valid && (r_count == c_last)) w_next = S_PARITY;
            S_PARITY: if (bus.bit_valid) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Frame accumulation: XOR fold, LSB-first placement and bit counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= 1'b0;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= 1'b0;
                        r_shift <= '0;
                        r_count <= '0;
                    end
                end
                S_DATA: begin
                    if (bus.bit_valid) begin
                        r_acc <= r_acc ^ bus.bit_in;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_count == c_cnt_w'(i)) begin
                                r_shift[i] <= bus.bit_in;
                            end
                        end
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers load on the edge entering DONE so they are valid
    // alongside frame_done, then hold until the next completed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else if ((r_state == S_PARITY) && bus.bit_valid) begin
            r_err  <= w_err;
            r_ok   <= ~w_err;
            r_data <= r_shift;
        end
    end

    // Status flags registered from the next state so outputs carry no
    // combinational path from the inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_DATA) || (w_next == S_PARITY);
            r_done <= (w_next == S_DONE);
        end
    end

    assign bus.busy       = r_busy;
    assign bus.bit_count  = r_count;
    assign bus.frame_done = r_done;
    assign bus.parity_ok  = r_ok;
    assign bus.parity_err = r_err;
    assign bus.data_out   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_checker
// Description : Self-checking bench for serial_parity_checker. Drives an
//               even-parity and an odd-parity instance with the same stream
//               and compares both against a word-level parity model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_parity_checker;

    localparam int c_bits = 8;

    logic clk;
    logic rst;
    logic start;
    logic bit_in;
    logic bit_valid;

    int n_checks;
    int n_errors;
    int fd_e;
    int fd_o;

    serial_parity_checker_if #(.DATA_BITS(c_bits)) ife ();
    serial_parity_checker_if #(.DATA_BITS(c_bits)) ifo ();

    assign ife.start     = start;
    assign ife.bit_in    = bit_in;
    assign ife.bit_valid = bit_valid;
    assign ifo.start     = start;
    assign ifo.bit_in    = bit_in;
    assign ifo.bit_valid = bit_valid;

    serial_parity_checker #(.DATA_BITS(c_bits), .ODD(1'b0)) u_even (
        .clk (clk),
        .rst (rst),
        .bus (ife)
    );

    serial_parity_checker #(.DATA_BITS(c_bits), .ODD(1'b1)) u_odd (
        .clk (clk),
        .rst (rst),
        .bus (ifo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed-frame pulses on each instance
    always @(negedge clk) begin
        if (ife.frame_done === 1'b1) fd_e++;
        if (ifo.frame_done === 1'b1) fd_o++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame passes when data ones plus the parity bit give the
    // total parity the instance expects (even -> 0, odd -> 1)
    function automatic logic exp_ok(input logic [7:0] d, input logic p, input bit odd);
        int ones;
        ones = $countones(d) + int'(p);
        return ((ones % 2) == int'(odd));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int maxgap, input int cnt);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int k = 0; k < g; k++) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
            step();
            check_val("cnt_hold", 32'(ife.bit_count), 32'(cnt));
        end
    endtask

    // One frame. start_at: pulse start in an idle cycle before that data bit.
    // abort_after: return after that many data bits (partial frame).
    task automatic run_frame(input logic [7:0] d, input logic p, input int maxgap,
                             input int start_at, input int abort_after);
        int fe0;
        int fo0;
        logic ok_e;
        logic ok_o;
        fe0 = fd_e;
        fo0 = fd_o;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("busy_rise", 32'(ife.busy), 32'd1);
        check_val("cnt_clear", 32'(ife.bit_count), 32'd0);
        for (int i = 0; i < c_bits; i++) begin
            if (i == abort_after) return;
            gap(maxgap, i);
            if (i == start_at) begin
                start     = 1'b1;
                bit_valid = 1'b0;
                step();
                start = 1'b0;
                check_val("start_ignored_cnt", 32'(ife.bit_count), 32'(i));
                check_val("start_ignored_busy", 32'(ife.busy), 32'd1);
            end
            bit_valid = 1'b1;
            bit_in    = d[i];
            step();
            bit_valid = 1'b0;
            check_val("cnt_step", 32'(ife.bit_count), 32'(i + 1));
        end
        gap(maxgap, c_bits);
        check_val("busy_parity", 32'(ife.busy), 32'd1);
        bit_valid = 1'b1;
        bit_in    = p;
        step();
        bit_valid = 1'b0;
        ok_e = exp_ok(d, p, 1'b0);
        ok_o = exp_ok(d, p, 1'b1);
        check_val("fdone_e", 32'(ife.frame_done), 32'd1);
        check_val("fdone_o", 32'(ifo.frame_done), 32'd1);
        check_val("busy_fall", 32'(ife.busy), 32'd0);
        check_val("data_e", 32'(ife.data_out), 32'(d));
        check_val("data_o", 32'(ifo.data_out), 32'(d));
        check_val("ok_e", 32'(ife.parity_ok), 32'(ok_e));
        check_val("err_e", 32'(ife.parity_err), 32'(!ok_e));
        check_val("ok_o", 32'(ifo.parity_ok), 32'(ok_o));
        check_val("err_o", 32'(ifo.parity_err), 32'(!ok_o));
        step();
        check_val("fdone_pulse", 32'(ife.frame_done), 32'd0);
        check_val("cnt_keep", 32'(ife.bit_count), 32'(c_bits));
        check_val("single_done_e", 32'(fd_e - fe0), 32'd1);
        check_val("single_done_o", 32'(fd_o - fo0), 32'd1);
    endtask

    initial begin
        int fe0;
        logic [7:0] d;
        logic [7:0] held;
        n_checks  = 0;
        n_errors  = 0;
        fd_e      = 0;
        fd_o      = 0;
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(ife.busy), 32'd0);
        check_val("rst_cnt", 32'(ife.bit_count), 32'd0);
        check_val("rst_fdone", 32'(ife.frame_done), 32'd0);
        check_val("rst_ok", 32'(ife.parity_ok), 32'd0);
        check_val("rst_err", 32'(ife.parity_err), 32'd0);
        check_val("rst_data", 32'(ife.data_out), 32'd0);
        rst = 1'b0;
        step();

        // Directed frames, gapless
        run_frame(8'hA5, 1'b0, 0, 99, 99);
        run_frame(8'hA5, 1'b1, 0, 99, 99);
        run_frame(8'h07, 1'b0, 0, 99, 99);
        run_frame(8'h00, 1'b0, 0, 99, 99);

        // Random gaps between bits
        run_frame(8'h3C, 1'b0, 5, 99, 99);

        // bit_valid while idle must not disturb anything
        held = ife.data_out;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            step();
        end
        bit_valid = 1'b0;
        check_val("idle_cnt", 32'(ife.bit_count), 32'(c_bits));
        check_val("idle_busy", 32'(ife.busy), 32'd0);
        check_val("idle_data", 32'(ife.data_out), 32'(held));
        check_val("idle_ok", 32'(ife.parity_ok), 32'd1);

        // start pulse mid-frame after 3 bits is ignored
        run_frame(8'h96, 1'b1, 0, 3, 99);

        // Asynchronous reset after 4 bits discards the frame
        fe0 = fd_e;
        run_frame(8'h5A, 1'b0, 2, 99, 4);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(ife.busy), 32'd0);
        check_val("arst_cnt", 32'(ife.bit_count), 32'd0);
        check_val("arst_data", 32'(ife.data_out), 32'd0);
        check_val("arst_ok", 32'(ife.parity_ok), 32'd0);
        check_val("arst_err", 32'(ife.parity_err), 32'd0);
        check_val("arst_err_o", 32'(ifo.parity_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_val("arst_no_done", 32'(fd_e - fe0), 32'd0);
        run_frame(8'hFF, 1'b0, 0, 99, 99);

        // Random frames with random gaps
        for (int f = 0; f < 10; f++) begin
            d = 8'($urandom);
            run_frame(d, 1'($urandom), 5, 99, 99);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
